turn_scheduler: RTL
===================

# turn_scheduler

Sequences the four player turns for the game. It owns the 2-bit turn index `T`, which the existing 2-to-4 player-select decoder turns into `da1..da4`. It rotates the turn among the players currently present, and ends a turn on player completion or on timeout. It latches the winner and holds the game-over state until the next start.

## Interface
Parameters:
- `TURN_TICKS`, default 1000: maximum cycles per turn before a forced advance. Legal values are ≥2.
- `TIMER_W`, default `$clog2(TURN_TICKS)`: width of the turn timer.

Ports:
- `clk`  in  1: the only clock; all state updates on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: pulse. Begins a game from IDLE or OVER.
- `active`  in  4: bit i set means player i is present. Sampled every cycle.
- `turn_done`  in  1: pulse. The current player has finished its turn.
- `win`  in  1: pulse. The current player has won.
- `T`  out  2: current player index, fed to the decoder.
- `turn_valid`  out  1: high while in PLAY.
- `turn_start`  out  1: one-cycle pulse in the first cycle of every turn.
- `timeout`  out  1: one-cycle pulse marking a turn that was ended by the timer.
- `game_over`  out  1: high in OVER.
- `winner`  out  2: index of the winning player. Valid while `game_over` is high.

## Operation
- All outputs are registered. Reset values: `T`=0, `turn_valid`=0, `turn_start`=0, `timeout`=0, `game_over`=0, `winner`=0, timer=0, state=IDLE.

States:
- **IDLE**
  - `start` with `active`≠0: go to PLAY. `T` = first set bit of `active`, scanning 0,1,2,3.
  - `start` with `active`=0: ignored, stay in IDLE.
- **PLAY**
  - The timer increments each cycle starting from 0.
  - Advance event: `turn_done`, OR timer==`TURN_TICKS`-1, OR `active[T]`==0.
  - Next player: scan T+1, T+2, T+3, T (mod 4) and take the first set bit. If the current player is the only active one, it keeps the turn.
  - On advance: `T` takes the new index, timer goes to 0, and `turn_start` pulses.
  - `timeout` pulses only when the timer was the sole cause of the advance.
- **OVER**
  - Entered when `win` occurs in PLAY. Sets `winner`=`T`, `game_over`=1, `turn_valid`=0.
  - `start` re-enters PLAY exactly as from IDLE, and clears `game_over`.
  - `winner` holds its value until the next win or `rst`.

Priorities within one cycle:
- In PLAY:
  - `active`==0: go to IDLE, regardless of other inputs.
  - Otherwise `win` beats `turn_done`, timeout, and dropout.
  - `start` is ignored.
- `rst` overrides everything. A reset mid-turn returns to IDLE with reset values on the next edge.
- `turn_done` / `win` are ignored outside PLAY.

## Timing
- Start latency:
  - `start` sampled high at edge k → at k+1: state PLAY, `turn_valid`=1, `turn_start`=1, valid `T`.
  - `turn_start` deasserts at k+2 unless another advance happens.
- Completion latency: `turn_done` sampled at edge k → new `T` and `turn_start`=1 at k+1; the timer reads 0 at k+1.
- Turn length:
  - With no input events, a turn lasts exactly `TURN_TICKS` cycles.
  - Turn start at cycle s → advance with `timeout`=1 and `turn_start`=1 at s+`TURN_TICKS`.
- Back-to-back completion: `turn_done` in the `turn_start` cycle is legal and advances again on the next edge.
- Win latency: `win` at edge k → `game_over`=1, `winner` valid, `turn_valid`=0 at k+1.
- `T` changes only on an advance, a start, or reset. It is stable for the whole turn.

## Structure
- Shared package or header `chicken_pkg` holds:
  - `NUM_PLAYERS`=4 and `PLAYER_W`=2.
  - State encodings `ST_IDLE`, `ST_PLAY`, `ST_OVER`, 2 bits.
- Sub-module `next_player_sel` is combinational:
  - Inputs: `cur`[1:0], `active`[3:0], `include_zero_base` (start mode scans from 0 instead of cur+1).
  - Outputs: `next`[1:0], `none` (high when `active`==0).
  - It is used for both start and advance selection.
- The timer, FSM and output registers live in `turn_scheduler`.

## Test plan
- `rst`; `active`=1111, `start` → `T`=0, `turn_start` pulse. Then 3× `turn_done` → `T`=1,2,3. A 4th `turn_done` → `T`=0 (wrap).
- `active`=1010, `start` → `T`=1. `turn_done` → `T`=3. `turn_done` → `T`=1. Clearing `active[3]` while `T`=3 → next cycle `T`=1 with `timeout`=0.
- `TURN_TICKS`=8, `active`=0100, no input events → `turn_start` and `timeout` every 8 cycles, with `T` staying 2.
- In PLAY with `T`=2, assert `win` and `turn_done` in the same cycle → `game_over`=1, `winner`=2, `turn_valid`=0, and `T` unchanged. Then `start` → PLAY with `game_over`=0.
- `start` with `active`=0000 → stays in IDLE with all outputs 0. In PLAY, `active`→0000 → IDLE next cycle.
- `rst` asserted mid-turn (timer=5, `T`=3) → next edge all outputs at reset values. A later `start` begins from player 0's scan.

Source files
------------

// File: rtl/chicken_pkg.sv
// Shared constants and state encodings for the turn scheduler.
// Provides player count/width and the 2-bit FSM state type.
package chicken_pkg;
  localparam int NUM_PLAYERS = 4;
  localparam int PLAYER_W    = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_e;
endpackage

// File: rtl/turn_scheduler_if.sv
// Game-control bundle between game logic (master) and scheduler (slave).
// Inputs: start, active, turn_done, win; outputs: T, flags, winner.
interface turn_scheduler_if;
  import chicken_pkg::*;

  logic                start;
  logic [3:0]          active;
  logic                turn_done;
  logic                win;
  logic [PLAYER_W-1:0] T;
  logic                turn_valid;
  logic                turn_start;
  logic                timeout;
  logic                game_over;
  logic [PLAYER_W-1:0] winner;

  modport master (
    output start, active, turn_done, win,
    input  T, turn_valid, turn_start,
    input  timeout, game_over, winner
  );

  modport slave (
    input  start, active, turn_done, win,
    output T, turn_valid, turn_start,
    output timeout, game_over, winner
  );
endinterface

// File: rtl/next_player_sel.sv
// Combinational round-robin pick of the next present player.
// Ports: cur, active, include_zero_base in; next, none out.
module next_player_sel
  import chicken_pkg::*;
(
  input  logic [PLAYER_W-1:0] cur,
  input  logic [3:0]          active,
  input  logic                include_zero_base,
  output logic [PLAYER_W-1:0] next,
  output logic                none
);

  logic [PLAYER_W-1:0] base;
  logic [PLAYER_W-1:0] idx;
  logic                found;

  // Scan base, base+1, ... mod 4; from cur+1 this ends on cur,
  // so a lone active player keeps the turn.
  always_comb begin
    next  = cur;
    none  = (active == 4'b0000);
    found = 1'b0;
    idx   = '0;
    base  = include_zero_base ? '0 : cur + 2'd1;
    for (int k = 0; k < NUM_PLAYERS; k++) begin
      idx = base + PLAYER_W'(k);
      if (!found && active[idx]) begin
        next  = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/turn_scheduler.sv
// Turn sequencer: rotates T over present players, ends turns on
// done/timeout/dropout, latches the winner. Ports: clk, rst, bus.
module turn_scheduler
  import chicken_pkg::*;
#(
  parameter int TURN_TICKS = 1000,
  parameter int TIMER_W    = $clog2(TURN_TICKS)
) (
  input  logic             clk,
  input  logic             rst,
  turn_scheduler_if.slave  bus
);

  state_e              state_q, state_d;
  logic [PLAYER_W-1:0] t_q, t_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic                valid_q, valid_d;
  logic                tstart_q, tstart_d;
  logic                tmo_q, tmo_d;
  logic                over_q, over_d;
  logic [PLAYER_W-1:0] winner_q, winner_d;

  logic [PLAYER_W-1:0] sel;
  logic                sel_none;
  logic                tick_end;
  logic                dropout;

  // Outside PLAY the selector serves start, which scans from 0.
  next_player_sel u_sel (
    .cur               (t_q),
    .active            (bus.active),
    .include_zero_base (state_q != ST_PLAY),
    .next              (sel),
    .none              (sel_none)
  );

  assign tick_end = (timer_q == TIMER_W'(TURN_TICKS - 1));
  assign dropout  = !bus.active[t_q];

  always_comb begin
    state_d  = state_q;
    t_d      = t_q;
    timer_d  = timer_q;
    valid_d  = valid_q;
    tstart_d = 1'b0;
    tmo_d    = 1'b0;
    over_d   = over_q;
    winner_d = winner_q;
    unique case (state_q)
      ST_IDLE, ST_OVER: begin
        if (bus.start && !sel_none) begin
          state_d  = ST_PLAY;
          t_d      = sel;
          timer_d  = '0;
          valid_d  = 1'b1;
          tstart_d = 1'b1;
          over_d   = 1'b0;
        end
      end
      ST_PLAY: begin
        if (sel_none) begin
          state_d = ST_IDLE;
          timer_d = '0;
          valid_d = 1'b0;
        end else if (bus.win) begin
          state_d  = ST_OVER;
          timer_d  = '0;
          valid_d  = 1'b0;
          over_d   = 1'b1;
          winner_d = t_q;
        end else if (bus.turn_done || tick_end || dropout) begin
          t_d      = sel;
          timer_d  = '0;
          tstart_d = 1'b1;
          tmo_d    = tick_end && !bus.turn_done && !dropout;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      t_q      <= '0;
      timer_q  <= '0;
      valid_q  <= 1'b0;
      tstart_q <= 1'b0;
      tmo_q    <= 1'b0;
      over_q   <= 1'b0;
      winner_q <= '0;
    end else begin
      state_q  <= state_d;
      t_q      <= t_d;
      timer_q  <= timer_d;
      valid_q  <= valid_d;
      tstart_q <= tstart_d;
      tmo_q    <= tmo_d;
      over_q   <= over_d;
      winner_q <= winner_d;
    end
  end

  assign bus.T          = t_q;
  assign bus.turn_valid = valid_q;
  assign bus.turn_start = tstart_q;
  assign bus.timeout    = tmo_q;
  assign bus.game_over  = over_q;
  assign bus.winner     = winner_q;

endmodule
